bus_timer_slave: RTL and testbench

Memory-mapped interval timer that acts as a responder on the shared system bus. The CPU bus interface and the bus arbiter sit on the initiator side. The block decodes the chip select, address strobe and read/write signals that an initiator drives through the bus. It answers each access with a one-cycle `rdy_` pulse after a programmable number of wait states. It holds a four-register timer that raises a level interrupt toward the CPU interrupt controller.

---
 rtl/bus_timer_slave.sv | 264 ++++++++++++++++++++++++++
 tb/tb_bus_timer_slave.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer_slave.sv
// -----------------------------------------------------------------------------
// bus_timer_slave
//
// Interval timer that sits as a responder on the shared system bus. An access
// is requested by the initiator holding cs_ and as_ low; the block latches
// addr/rw/wr_data, optionally inserts WAIT_CYCLES wait states, then answers
// with a single-cycle active-low rdy_ pulse.
//
// Register map (word index on addr):
//   0 CTRL  : bit0 start, bit1 periodic
//   1 INTR  : bit0 irq flag (write 0 clears, write 1 sets)
//   2 EXPR  : expiry value
//   3 COUNT : free-running count while start=1
//
// Parameters:
//   WAIT_CYCLES  extra wait states before rdy_ (0..15)
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous reset, active low
//   cs_      chip select, active low
//   as_      address strobe, active low, held by initiator until rdy_
//   rw       1 = read, 0 = write
//   addr     register word index
//   wr_data  write data, valid with as_
//   rd_data  read data, non-zero only during the rdy_ cycle of a read
//   rdy_     access complete, active low, one cycle per access
//   irq      level interrupt, mirrors INTR bit0
//
// Build option:
//   TIMER_COUNT_WR_EN  when defined, COUNT is writable through address 3;
//                      otherwise writes to COUNT complete but are discarded.
//
// Bus handshake: a request is accepted only in IDLE when cs_=0 and as_=0 on a
// rising edge. The request is then owned by the slave; later changes on the
// bus inputs are ignored until the FSM returns to IDLE. rdy_ is low for
// exactly the ACK cycle, and ACK always returns to IDLE, so rdy_ can never be
// low on two consecutive cycles.
// -----------------------------------------------------------------------------
module bus_timer_slave #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic        irq
);

`ifdef TIMER_COUNT_WR_EN
    localparam bit COUNT_WRITABLE = 1'b1;
`else
    localparam bit COUNT_WRITABLE = 1'b0;
`endif

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_INTR  = 2'd1;
    localparam logic [1:0] ADDR_EXPR  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Access FSM
    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_cnt_next;
    logic        latch_req;
    logic        req;

    // Latched request
    logic [1:0]  addr_q;
    logic        rw_q;
    logic [31:0] data_q;

    logic        rdy_q;

    // Timer registers
    logic        ctrl_start;
    logic        ctrl_periodic;
    logic        intr_irq;
    logic [31:0] expr_q;
    logic [31:0] count_q;

    logic        ctrl_start_next;
    logic        ctrl_periodic_next;
    logic        intr_irq_next;
    logic [31:0] expr_next;
    logic [31:0] count_next;

    logic        wr_commit;
    logic        expire;
    logic [31:0] rd_mux;

    assign req = ~cs_ & ~as_;

    // ------------------------------------------------------------------
    // Access FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        latch_req     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    latch_req = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_ACK;
                    end else begin
                        // Counter counts the remaining WAIT cycles after
                        // this one, so WAIT lasts exactly WAIT_CYCLES cycles.
                        state_next    = ST_WAIT;
                        wait_cnt_next = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = ST_ACK;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Access FSM: state register and registered rdy_
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            rdy_q    <= 1'b1;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            // Registered from next state so rdy_ is low exactly while in ACK.
            rdy_q    <= (state_next != ST_ACK);
        end
    end

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= 2'd0;
            rw_q   <= 1'b0;
            data_q <= 32'd0;
        end else if (latch_req) begin
            addr_q <= addr;
            rw_q   <= rw;
            data_q <= wr_data;
        end
    end

    // A write takes effect on the edge that leaves ACK.
    assign wr_commit = (state == ST_ACK) && !rw_q;

    // ------------------------------------------------------------------
    // Timer next-state. The timer update is computed first and the bus write
    // then overrides it, which gives the written value priority over
    // increment/clear. The irq set from an expiry is ORed back in so that an
    // expiry always wins against a clearing write.
    // ------------------------------------------------------------------
    assign expire = ctrl_start && (count_q == expr_q);

    always_comb begin
        ctrl_start_next    = ctrl_start;
        ctrl_periodic_next = ctrl_periodic;
        intr_irq_next      = intr_irq;
        expr_next          = expr_q;
        count_next         = count_q;

        if (ctrl_start) begin
            if (expire) begin
                count_next    = 32'd0;
                intr_irq_next = 1'b1;
                if (!ctrl_periodic) begin
                    ctrl_start_next = 1'b0;
                end
            end else begin
                // Wraps 0xFFFFFFFF -> 0 silently; only equality with EXPR
                // produces an event.
                count_next = count_q + 32'd1;
            end
        end

        if (wr_commit) begin
            case (addr_q)
                ADDR_CTRL: begin
                    ctrl_start_next    = data_q[0];
                    ctrl_periodic_next = data_q[1];
                end
                ADDR_INTR: begin
                    intr_irq_next = data_q[0] | expire;
                end
                ADDR_EXPR: begin
                    expr_next = data_q;
                end
                ADDR_COUNT: begin
                    if (COUNT_WRITABLE) begin
                        count_next = data_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_start    <= 1'b0;
            ctrl_periodic <= 1'b0;
            intr_irq      <= 1'b0;
            expr_q        <= 32'd0;
            count_q       <= 32'd0;
        end else begin
            ctrl_start    <= ctrl_start_next;
            ctrl_periodic <= ctrl_periodic_next;
            intr_irq      <= intr_irq_next;
            expr_q        <= expr_next;
            count_q       <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Read path: register contents as they stand during the ACK cycle,
    // forced to zero at all other times and for writes.
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = 32'd0;
        case (addr_q)
            ADDR_CTRL:  rd_mux = {30'd0, ctrl_periodic, ctrl_start};
            ADDR_INTR:  rd_mux = {31'd0, intr_irq};
            ADDR_EXPR:  rd_mux = expr_q;
            ADDR_COUNT: rd_mux = count_q;
            default:    rd_mux = 32'd0;
        endcase
    end

    assign rd_data = ((state == ST_ACK) && rw_q) ? rd_mux : 32'd0;
    assign rdy_    = rdy_q;
    assign irq     = intr_irq;

endmodule

// File: tb/tb_bus_timer_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_timer_slave
//
// Two instances of bus_timer_slave: dut0 with WAIT_CYCLES=0 and dut1 with
// WAIT_CYCLES=3, each with its own bus signals and a shared reset. A
// behavioural model of the register file and timer advances once per clock
// edge; bus accesses are driven by a task that knows the expected latency of
// each instance and predicts read data from the model.
// -----------------------------------------------------------------------------
module tb_bus_timer_slave;

    localparam int W0 = 0;
    localparam int W1 = 3;

`ifdef TIMER_COUNT_WR_EN
    localparam bit COUNT_WR = 1'b1;
`else
    localparam bit COUNT_WR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- DUT signals ----------------
    logic        cs0_, as0_, rw0;
    logic [1:0]  addr0;
    logic [31:0] wd0, rd0;
    logic        rdy0_, irq0;

    logic        cs1_, as1_, rw1;
    logic [1:0]  addr1;
    logic [31:0] wd1, rd1;
    logic        rdy1_, irq1;

    bus_timer_slave #(.WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset(reset), .cs_(cs0_), .as_(as0_), .rw(rw0),
        .addr(addr0), .wr_data(wd0), .rd_data(rd0), .rdy_(rdy0_), .irq(irq0)
    );

    bus_timer_slave #(.WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(reset), .cs_(cs1_), .as_(as1_), .rw(rw1),
        .addr(addr1), .wr_data(wd1), .rd_data(rd1), .rdy_(rdy1_), .irq(irq1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    logic        m_start [2];
    logic        m_per   [2];
    logic        m_irq   [2];
    logic [31:0] m_expr  [2];
    logic [31:0] m_count [2];
    logic        pw_v    [2];
    logic [1:0]  pw_addr [2];
    logic [31:0] pw_data [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_start[s] = 1'b0;
            m_per[s]   = 1'b0;
            m_irq[s]   = 1'b0;
            m_expr[s]  = 32'd0;
            m_count[s] = 32'd0;
            pw_v[s]    = 1'b0;
            pw_addr[s] = 2'd0;
            pw_data[s] = 32'd0;
        end
    endtask

    // One clock edge of the timer rules, followed by any bus write that
    // commits on this edge (write beats timer, except expiry always sets irq).
    task automatic model_edge();
        for (int s = 0; s < 2; s++) begin
            logic fire;
            fire = m_start[s] && (m_count[s] == m_expr[s]);
            if (fire) begin
                m_count[s] = 32'd0;
                m_irq[s]   = 1'b1;
                if (!m_per[s]) m_start[s] = 1'b0;
            end else if (m_start[s]) begin
                m_count[s] = m_count[s] + 32'd1;
            end
            if (pw_v[s]) begin
                case (pw_addr[s])
                    2'd0: begin
                        m_start[s] = pw_data[s][0];
                        m_per[s]   = pw_data[s][1];
                    end
                    2'd1: m_irq[s] = fire ? 1'b1 : pw_data[s][0];
                    2'd2: m_expr[s] = pw_data[s];
                    default: if (COUNT_WR) m_count[s] = pw_data[s];
                endcase
                pw_v[s] = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] model_read(input int s, input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_per[s], m_start[s]};
            2'd1:    return {31'd0, m_irq[s]};
            2'd2:    return m_expr[s];
            default: return m_count[s];
        endcase
    endfunction

    function automatic logic get_rdy(input int s);
        return (s == 0) ? rdy0_ : rdy1_;
    endfunction

    function automatic logic [31:0] get_rd(input int s);
        return (s == 0) ? rd0 : rd1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int s, input logic c, input logic a, input logic r,
                         input logic [1:0] ad, input logic [31:0] d);
        if (s == 0) begin
            cs0_ = c; as0_ = a; rw0 = r; addr0 = ad; wd0 = d;
        end else begin
            cs1_ = c; as1_ = a; rw1 = r; addr1 = ad; wd1 = d;
        end
    endtask

    // Advance one edge; outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("irq0", 32'(irq0), 32'(m_irq[0]));
        check("irq1", 32'(irq1), 32'(m_irq[1]));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            check("idle_rdy0", 32'(rdy0_), 32'd1);
            check("idle_rdy1", 32'(rdy1_), 32'd1);
            check("idle_rd0", rd0, 32'd0);
            check("idle_rd1", rd1, 32'd0);
        end
    endtask

    task automatic bus_access(input int s, input logic r, input logic [1:0] a, input logic [31:0] d);
        int w;
        w = (s == 0) ? W0 : W1;
        drive(s, 1'b0, 1'b0, r, a, d);
        tick();  // request edge
        // Strobe stays low and the other fields change: none of it may matter.
        drive(s, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
        for (int k = 0; k < w; k++) begin
            check("wait_rdy", 32'(get_rdy(s)), 32'd1);
            check("wait_rd_data", get_rd(s), 32'd0);
            tick();
        end
        check("ack_rdy", 32'(get_rdy(s)), 32'd0);
        if (r) begin
            check($sformatf("rd_data_a%0d", a), get_rd(s), model_read(s, a));
        end else begin
            pw_v[s]    = 1'b1;
            pw_addr[s] = a;
            pw_data[s] = d;
        end
        tick();  // edge leaving ACK
        check("rdy_single", 32'(get_rdy(s)), 32'd1);
        check("rd_data_after", get_rd(s), 32'd0);
        drive(s, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic reset_pulse();
        reset = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        drive(1, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        model_reset();
        #2;
        check("rst_rdy0", 32'(rdy0_), 32'd1);
        check("rst_rdy1", 32'(rdy1_), 32'd1);
        check("rst_rd0", rd0, 32'd0);
        check("rst_rd1", rd1, 32'd0);
        check("rst_irq0", 32'(irq0), 32'd0);
        check("rst_irq1", 32'(irq1), 32'd0);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_count(input int s, input logic [31:0] v);
        int i;
        i = 0;
        while (m_count[s] != v && i < 300) begin
            tick();
            i++;
        end
        if (m_count[s] != v) begin
            n_checks++;
            n_errors++;
            $error("FAIL wait_count: count %h never reached %h", m_count[s], v);
        end
    endtask

    task automatic read_all(input int s);
        for (int a = 0; a < 4; a++) bus_access(s, 1'b1, 2'(a), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        drive(1, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        model_reset();
        #1;
        reset_pulse();
        idle(2);
        read_all(0);
        read_all(1);

        // Write then read, zero wait states
        bus_access(0, 1'b0, 2'd2, 32'h0000_0010);
        bus_access(0, 1'b1, 2'd2, 32'd0);
        check("expr_readback", m_expr[0], 32'h0000_0010);

        // Wait states: rdy_ in the 4th cycle after the request edge
        bus_access(1, 1'b1, 2'd0, 32'd0);
        bus_access(1, 1'b0, 2'd2, $urandom);
        bus_access(1, 1'b1, 2'd2, 32'd0);

        // One-shot
        bus_access(0, 1'b0, 2'd2, 32'd5);
        bus_access(0, 1'b0, 2'd0, 32'h1);
        idle(8);
        check("oneshot_irq", 32'(irq0), 32'd1);
        bus_access(0, 1'b1, 2'd0, 32'd0);
        bus_access(0, 1'b1, 2'd3, 32'd0);
        bus_access(0, 1'b0, 2'd1, 32'd0);
        check("oneshot_irq_clr", 32'(irq0), 32'd0);

        // Software set / clear of INTR
        bus_access(0, 1'b0, 2'd1, 32'h1);
        check("sw_irq_set", 32'(irq0), 32'd1);
        bus_access(0, 1'b0, 2'd1, 32'd0);

        // CTRL write landing on the expiry edge: written value wins
        bus_access(0, 1'b0, 2'd0, 32'h1);
        wait_count(0, 32'd4);
        bus_access(0, 1'b0, 2'd0, 32'h1);
        check("ctrl_coincide_irq", 32'(irq0), 32'd1);
        bus_access(0, 1'b1, 2'd0, 32'd0);
        idle(10);  // one-shot run ends, COUNT back at 0
        bus_access(0, 1'b0, 2'd1, 32'd0);

        // Periodic
        bus_access(0, 1'b0, 2'd2, 32'd3);
        bus_access(0, 1'b0, 2'd0, 32'h3);
        idle(10);
        bus_access(0, 1'b1, 2'd0, 32'd0);
        wait_count(0, 32'd0);
        bus_access(0, 1'b0, 2'd1, 32'd0);  // commits on count 1: clears
        check("per_irq_clr", 32'(irq0), 32'd0);
        wait_count(0, 32'd2);
        bus_access(0, 1'b0, 2'd1, 32'd0);  // commits on expiry: set wins
        check("per_irq_setwins", 32'(irq0), 32'd1);
        bus_access(0, 1'b0, 2'd0, 32'h1);  // back to one-shot, stops at 0
        idle(6);
        bus_access(0, 1'b0, 2'd1, 32'd0);

        // COUNT write and wrap
        bus_access(0, 1'b0, 2'd2, 32'd1);
        bus_access(0, 1'b0, 2'd3, 32'hFFFF_FFFE);
        bus_access(0, 1'b1, 2'd3, 32'd0);
        bus_access(0, 1'b0, 2'd0, 32'h1);
        bus_access(0, 1'b1, 2'd3, 32'd0);
        idle(6);
        check("wrap_irq", 32'(irq0), 32'd1);
        bus_access(0, 1'b0, 2'd1, 32'd0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  a;
            logic        r;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            r = 1'($urandom_range(0, 1));
            d = (a == 2'd2) ? 32'($urandom_range(0, 12)) : $urandom;
            bus_access(0, r, a, d);
            idle($urandom_range(0, 3));
        end
        for (int i = 0; i < 12; i++) begin
            logic [1:0]  a;
            logic        r;
            logic [31:0] d;
            a = 2'($urandom_range(0, 3));
            r = 1'($urandom_range(0, 1));
            d = (a == 2'd2) ? 32'($urandom_range(0, 12)) : $urandom;
            bus_access(1, r, a, d);
            idle($urandom_range(0, 2));
        end

        // Reset in the middle of a wait-state access
        bus_access(0, 1'b0, 2'd2, 32'd7);
        bus_access(0, 1'b0, 2'd0, 32'h3);
        drive(1, 1'b0, 1'b0, 1'b0, 2'd2, 32'hDEAD_BEEF);
        tick();
        tick();
        check("abort_in_wait", 32'(rdy1_), 32'd1);
        reset_pulse();
        idle(2);
        read_all(0);
        read_all(1);
        bus_access(1, 1'b0, 2'd2, 32'h0000_0055);
        bus_access(1, 1'b1, 2'd2, 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
